// File: rtl/vip_pkg.sv
// Shared VIP types and legality limits.
// Imported by the frame gate and its delay line.
package vip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_RUN
  } vip_state_e;

  localparam int VIP_DELAY_MAX = 8;
  localparam int VIP_BEATS_MAX = 4;

endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth shift register with reset value and a stage-1 tap.
// Carries the whole pixel bundle so sideband stays aligned with data.
module video_delay_line #(
  parameter int          W   = 8,
  parameter int          D   = 2,
  parameter int          TAP = 0,
  parameter logic [W-1:0] RV = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         tap1
);

  logic [W-1:0] pipe [D];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++)
        pipe[i] <= RV;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < D; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign q    = pipe[D-1];
  assign tap1 = pipe[0][TAP];

endmodule

// File: rtl/video_frame_gate.sv
// Whole-frame stream gate with warm-up skip and beat-group strobe.
// VIDEO_FRAME_GATE_CNT_EN adds frame_cnt / frame_drop.
module video_frame_gate
  import vip_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int DELAY       = 2,
  parameter int SKIP_FRAMES = 0,
  parameter int BEATS       = 2,
  parameter bit VS_POL      = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] pre_data,
  input  logic              pre_vs,
  input  logic              pre_de,
  output logic [DATA_W-1:0] post_data,
  output logic              post_vs,
  output logic              post_de,
  output logic              post_data_en,
  output logic              locked
`ifdef VIDEO_FRAME_GATE_CNT_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic              frame_drop
`endif
);

  localparam int DL = (DELAY < 1) ? 1 :
    (DELAY > VIP_DELAY_MAX) ? VIP_DELAY_MAX : DELAY;
  localparam int BT = (BEATS < 1) ? 1 :
    (BEATS > VIP_BEATS_MAX) ? VIP_BEATS_MAX : BEATS;
  localparam int W = DATA_W + 4;
  localparam logic VS_IDLE = !VS_POL;
  localparam logic [1:0] BLAST = 2'(BT - 1);
  localparam logic [7:0] SKIP_N = 8'(SKIP_FRAMES);
  localparam logic [W-1:0] RV =
    {1'b0, 1'b0, 1'b0, VS_IDLE, {DATA_W{1'b0}}};

  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         vs_q;
  logic         fs;
  logic [1:0]   bcnt;
  logic         strobe;
  vip_state_e   state;
  vip_state_e   state_nx;
  logic [7:0]   skip_cnt;
  logic [7:0]   skip_nx;
  logic         gate_cur;
  logic         gate_in;
  logic         pass;

  assign fs     = (pre_vs == VS_POL) && (vs_q != VS_POL);
  assign strobe = pre_de && (bcnt == BLAST);

  always_ff @(posedge clk) begin
    if (rst || !pre_de)
      bcnt <= '0;
    else
      bcnt <= (bcnt == BLAST) ? 2'd0 : bcnt + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
      gate_cur <= 1'b0;
      locked   <= 1'b0;
    end else begin
      state    <= state_nx;
      skip_cnt <= skip_nx;
      locked   <= (state_nx == ST_RUN);
      if (fs)
        gate_cur <= pass;
    end
  end

  // Decisions are taken only at frame starts; en is ignored otherwise.
  always_comb begin
    state_nx = state;
    skip_nx  = skip_cnt;
    pass     = 1'b0;
    if (fs) begin
      unique case (state)
        ST_IDLE: begin
          if (en) begin
            if (SKIP_N == 8'd0) begin
              state_nx = ST_RUN;
              pass     = 1'b1;
            end else begin
              state_nx = ST_SKIP;
              skip_nx  = 8'd1;
            end
          end
        end
        ST_SKIP: begin
          if (!en) begin
            state_nx = ST_IDLE;
          end else if (skip_cnt == SKIP_N) begin
            state_nx = ST_RUN;
            pass     = 1'b1;
          end else begin
            skip_nx = skip_cnt + 8'd1;
          end
        end
        ST_RUN: begin
          if (en)
            pass = 1'b1;
          else
            state_nx = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  assign gate_in = fs ? pass : gate_cur;
  assign din = {gate_in, strobe, pre_de, pre_vs, pre_data};

  video_delay_line #(
    .W   (W),
    .D   (DL),
    .TAP (DATA_W),
    .RV  (RV)
  ) u_dly (
    .clk  (clk),
    .rst  (rst),
    .d    (din),
    .q    (dout),
    .tap1 (vs_q)
  );

  always_ff @(posedge clk) begin
    if (rst || !dout[DATA_W+3]) begin
      post_data    <= '0;
      post_vs      <= VS_IDLE;
      post_de      <= 1'b0;
      post_data_en <= 1'b0;
    end else begin
      post_data    <= dout[DATA_W-1:0];
      post_vs      <= dout[DATA_W];
      post_de      <= dout[DATA_W+1];
      post_data_en <= dout[DATA_W+2];
    end
  end

`ifdef VIDEO_FRAME_GATE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt  <= '0;
      frame_drop <= 1'b0;
    end else begin
      frame_drop <= fs && en && !pass;
      if (fs && pass)
        frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
